// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control and a global stall.
// Define PIPELINED_BARREL_SHIFTER_ROTATE_EN to build the wrap-around muxes; otherwise op 11 behaves as SRL.
module pipelined_barrel_shifter #(
    parameter int WIDTH            = 64,
    parameter int LAYERS_PER_STAGE = 2,
    parameter int TAG_W            = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [WIDTH-1:0]   in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int SH_W    = $clog2(WIDTH);
    localparam int NSTAGES = (SH_W + LAYERS_PER_STAGE - 1) / LAYERS_PER_STAGE;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic stall;

    function automatic logic [WIDTH-1:0] bitReverse(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // Applies the right-shift layers [first, first+LAYERS_PER_STAGE); vacated MSBs take the fill pattern.
    function automatic logic [WIDTH-1:0] shiftLayers(
        input logic [WIDTH-1:0] d,
        input logic [SH_W-1:0]  amt,
        input logic             sign,
        input logic             rot,
        input int               first
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        r = d;
        for (int k = first; k < SH_W; k++) begin
            if (k < first + LAYERS_PER_STAGE && amt[k]) begin
                fill = rot ? r : {WIDTH{sign}};
                r    = (r >> (1 << k)) | (fill << (WIDTH - (1 << k)));
            end
        end
        return r;
    endfunction

    for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
        logic               valid_q;
        logic [WIDTH-1:0]   data_q;
        logic [SH_W-1:0]    shamt_q;
        logic [1:0]         op_q;
        logic               sign_q;
        logic [TAG_W-1:0]   tag_q;

        logic               srcValid;
        logic [WIDTH-1:0]   srcData;
        logic [SH_W-1:0]    srcShamt;
        logic [1:0]         srcOp;
        logic               srcSign;
        logic               srcRot;
        logic [TAG_W-1:0]   srcTag;
        logic [WIDTH-1:0]   data_d;

        if (s == 0) begin : g_first
            // Left shifts ride the right-shift tree on a bit-reversed operand.
            assign srcValid = in_valid;
            assign srcData  = (in_op == OP_SLL) ? bitReverse(in_data) : in_data;
            assign srcShamt = in_shamt[SH_W-1:0];
            assign srcOp    = in_op;
            assign srcSign  = (in_op == OP_SRA) & in_data[WIDTH-1];
            assign srcTag   = in_tag;
        end else begin : g_next
            assign srcValid = g_stage[s-1].valid_q;
            assign srcData  = g_stage[s-1].data_q;
            assign srcShamt = g_stage[s-1].shamt_q;
            assign srcOp    = g_stage[s-1].op_q;
            assign srcSign  = g_stage[s-1].sign_q;
            assign srcTag   = g_stage[s-1].tag_q;
        end

`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
        assign srcRot = (srcOp == OP_ROR);
`else
        assign srcRot = 1'b0;
`endif

        always_comb begin
            data_d = shiftLayers(srcData, srcShamt, srcSign, srcRot, s * LAYERS_PER_STAGE);
            if (s == NSTAGES - 1 && srcOp == OP_SLL) begin
                data_d = bitReverse(data_d);
            end
        end

        // Every stage moves in lockstep; a stall freezes the whole pipe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                shamt_q <= '0;
                op_q    <= '0;
                sign_q  <= 1'b0;
                tag_q   <= '0;
            end else if (!stall) begin
                valid_q <= srcValid;
                data_q  <= data_d;
                shamt_q <= srcShamt;
                op_q    <= srcOp;
                sign_q  <= srcSign;
                tag_q   <= srcTag;
            end
        end
    end

    assign out_valid = g_stage[NSTAGES-1].valid_q;
    assign out_data  = g_stage[NSTAGES-1].data_q;
    assign out_tag   = g_stage[NSTAGES-1].tag_q;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    logic unused_bits;
    assign unused_bits = ^{in_shamt[WIDTH-1:SH_W], g_stage[NSTAGES-1].shamt_q,
                           g_stage[NSTAGES-1].op_q, g_stage[NSTAGES-1].sign_q};

endmodule
